// File: rtl/rv32im_div_sequencer.sv
// Multicycle radix-2 restoring divider for RV32IM DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Optional macro DIV_FAST_PATH_EN: divide-by-zero, signed overflow and |a|<|b| finish one cycle after accept.
module rv32im_div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             start_i,
  input  logic [4:0]       select_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  input  logic [4:0]       dest_in_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] result_o,
  output logic [4:0]       dest_out_o,
  output logic             done_o,
  output logic             busy_o,
  output logic             stall_o
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [4:0] SEL_DIV  = 5'b10001;
  localparam logic [4:0] SEL_DIVU = 5'b10101;
  localparam logic [4:0] SEL_REM  = 5'b11001;
  localparam logic [4:0] SEL_REMU = 5'b11101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] v);
    return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic is_signed);
    return (is_signed && v[WIDTH-1]) ? neg(v) : v;
  endfunction

  state_e           state_q, state_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [4:0]       dest_q, dest_d;

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             is_rem_q, is_rem_d;
  logic [4:0]       tag_q, tag_d;

  logic             is_div_op, op_signed, op_rem, accept;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   rem_shift;
  logic             trial_ok;
  logic [WIDTH-1:0] trial_diff;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  assign is_div_op = (select_i == SEL_DIV) || (select_i == SEL_DIVU) ||
                     (select_i == SEL_REM) || (select_i == SEL_REMU);
  assign op_signed = (select_i == SEL_DIV) || (select_i == SEL_REM);
  assign op_rem    = (select_i == SEL_REM) || (select_i == SEL_REMU);
  assign accept    = (state_q == S_IDLE) && start_i && is_div_op && !flush_i;

  assign a_mag = mag(data1_i, op_signed);
  assign b_mag = mag(data2_i, op_signed);

  // rem never exceeds the divisor, so the shifted value fits WIDTH+1 bits and
  // a successful trial difference fits back into WIDTH bits.
  assign rem_shift  = {rem_q, quo_q[WIDTH-1]};
  assign trial_ok   = rem_shift >= {1'b0, dvs_q};
  assign trial_diff = rem_shift[WIDTH-1:0] - dvs_q;

  assign quo_fix = qneg_q ? neg(quo_q) : quo_q;
  assign rem_fix = rneg_q ? neg(rem_q) : rem_q;

`ifdef DIV_FAST_PATH_EN
  logic             fast_zero, fast_ovf, fast_hit;
  logic [WIDTH-1:0] fast_res;

  assign fast_zero = (data2_i == '0);
  assign fast_ovf  = op_signed && (data1_i == {1'b1, {(WIDTH-1){1'b0}}}) && (data2_i == '1);
  assign fast_hit  = fast_zero || fast_ovf || (a_mag < b_mag);

  always_comb begin
    if (fast_zero) begin
      fast_res = op_rem ? data1_i : '1;
    end else if (fast_ovf) begin
      fast_res = op_rem ? '0 : data1_i;
    end else begin
      fast_res = op_rem ? data1_i : '0;
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    dest_d   = dest_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    is_rem_d = is_rem_q;
    tag_d    = tag_q;

    if (flush_i && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            rem_d    = '0;
            quo_d    = a_mag;
            dvs_d    = b_mag;
            // A zero divisor must yield all-ones for DIV as well, so no quotient negation then.
            qneg_d   = op_signed && (data1_i[WIDTH-1] ^ data2_i[WIDTH-1]) && (data2_i != '0);
            rneg_d   = op_signed && data1_i[WIDTH-1];
            is_rem_d = op_rem;
            tag_d    = dest_in_i;
            cnt_d    = CNT_W'(WIDTH-1);
`ifdef DIV_FAST_PATH_EN
            if (fast_hit) begin
              result_d = fast_res;
              dest_d   = dest_in_i;
              state_d  = S_DONE;
            end else begin
              busy_d  = 1'b1;
              state_d = S_CALC;
            end
`else
            busy_d  = 1'b1;
            state_d = S_CALC;
`endif
          end
        end
        S_CALC: begin
          quo_d = {quo_q[WIDTH-2:0], trial_ok};
          rem_d = trial_ok ? trial_diff : rem_shift[WIDTH-1:0];
          if (cnt_q == '0) begin
            state_d = S_FIX;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        S_FIX: begin
          result_d = is_rem_q ? rem_fix : quo_fix;
          dest_d   = tag_q;
          busy_d   = 1'b0;
          state_d  = S_DONE;
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      dest_q   <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      dest_q   <= dest_d;
    end
  end

  // Working operands are always loaded at accept before use, so they carry no reset.
  always_ff @(posedge clk_i) begin
    rem_q    <= rem_d;
    quo_q    <= quo_d;
    dvs_q    <= dvs_d;
    qneg_q   <= qneg_d;
    rneg_q   <= rneg_d;
    is_rem_q <= is_rem_d;
    tag_q    <= tag_d;
  end

  assign result_o   = result_q;
  assign dest_out_o = dest_q;
  assign done_o     = (state_q == S_DONE);
  assign busy_o     = busy_q;
  assign stall_o    = (start_i && (state_q == S_IDLE) && is_div_op) || busy_q;

endmodule

// File: tb/tb_rv32im_div_sequencer.sv
// Testbench for rv32im_div_sequencer: directed vector table, multi-cycle corner sequences,
// and randomized operations against an arithmetic reference model (DIV_FAST_PATH_EN aware).
module tb_rv32im_div_sequencer;

  localparam logic [4:0]  OP_DIV  = 5'b10001;
  localparam logic [4:0]  OP_DIVU = 5'b10101;
  localparam logic [4:0]  OP_REM  = 5'b11001;
  localparam logic [4:0]  OP_REMU = 5'b11101;
  localparam logic [4:0]  OP_ADD  = 5'b00000;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        reset_ni;
  logic        start_i;
  logic [4:0]  select_i;
  logic [31:0] data1_i;
  logic [31:0] data2_i;
  logic [4:0]  dest_in_i;
  logic        flush_i;
  logic [31:0] result_o;
  logic [4:0]  dest_out_o;
  logic        done_o;
  logic        busy_o;
  logic        stall_o;

  always #5 clk = ~clk;

  rv32im_div_sequencer #(.WIDTH(32)) dut (
    .clk_i      (clk),
    .reset_ni   (reset_ni),
    .start_i    (start_i),
    .select_i   (select_i),
    .data1_i    (data1_i),
    .data2_i    (data2_i),
    .dest_in_i  (dest_in_i),
    .flush_i    (flush_i),
    .result_o   (result_o),
    .dest_out_o (dest_out_o),
    .done_o     (done_o),
    .busy_o     (busy_o),
    .stall_o    (stall_o)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] last_res = '0;
  logic [4:0]  last_dst = '0;

  typedef struct {
    string       name;
    logic [4:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  dst;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic is_signed_op(input logic [4:0] sel);
    return (sel == OP_DIV) || (sel == OP_REM);
  endfunction

  // RISC-V M-extension semantics written directly as arithmetic.
  function automatic logic [31:0] ref_result(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (is_signed_op(sel) && a == INT_MIN && b == 32'hFFFF_FFFF) begin
      q = INT_MIN;
      r = 32'd0;
    end else if (is_signed_op(sel)) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return ((sel == OP_REM) || (sel == OP_REMU)) ? r : q;
  endfunction

  function automatic int exp_latency(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_FAST_PATH_EN
    logic [31:0] ma, mb;
    ma = (is_signed_op(sel) && a[31]) ? -a : a;
    mb = (is_signed_op(sel) && b[31]) ? -b : b;
    if (b == 32'd0 || (is_signed_op(sel) && a == INT_MIN && b == 32'hFFFF_FFFF) || ma < mb)
      return 1;
    return 34;
`else
    return 34;
`endif
  endfunction

  // Accept happens in the cycle where start is driven (cycle 0); DONE is counted from there.
  task automatic run_op(input string name, input logic [4:0] sel, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] dst, input logic [31:0] exp_res,
                        input bit pre_tick);
    int lat;
    int exp_lat;
    exp_lat = exp_latency(sel, a, b);
    if (pre_tick) tick();
    start_i   = 1'b1;
    select_i  = sel;
    data1_i   = a;
    data2_i   = b;
    dest_in_i = dst;
    #1;
    check({name, " stall@accept"}, 32'(stall_o), 32'd1);
    lat = 0;
    while (lat < 60) begin
      tick();
      lat++;
      if (lat == 1) begin
        start_i = 1'b0;
        check({name, " busy@c1"}, 32'(busy_o), 32'(exp_lat > 1));
      end
      if (done_o) break;
    end
    check({name, " latency"}, lat, exp_lat);
    check({name, " result"}, result_o, exp_res);
    check({name, " dest"}, 32'(dest_out_o), 32'(dst));
    check({name, " busy@done"}, 32'(busy_o), 32'd0);
    check({name, " stall@done"}, 32'(stall_o), 32'd0);
    last_res = exp_res;
    last_dst = dst;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 5ms");
    $fatal(1, "timeout");
  end

  initial begin
    int nd;

    vecs.push_back('{"div 100/7",       OP_DIV,  32'd100,       32'd7,         5'd3,  32'd14});
    vecs.push_back('{"rem 100/7",       OP_REM,  32'd100,       32'd7,         5'd4,  32'd2});
    vecs.push_back('{"rem -7/2",        OP_REM,  32'hFFFF_FFF9, 32'd2,         5'd5,  32'hFFFF_FFFF});
    vecs.push_back('{"div -7/2",        OP_DIV,  32'hFFFF_FFF9, 32'd2,         5'd6,  32'hFFFF_FFFD});
    vecs.push_back('{"divu fff9/2",     OP_DIVU, 32'hFFFF_FFF9, 32'd2,         5'd7,  32'h7FFF_FFFC});
    vecs.push_back('{"divu 5/0",        OP_DIVU, 32'd5,         32'd0,         5'd8,  32'hFFFF_FFFF});
    vecs.push_back('{"remu 5/0",        OP_REMU, 32'd5,         32'd0,         5'd9,  32'd5});
    vecs.push_back('{"div ovf",         OP_DIV,  INT_MIN,       32'hFFFF_FFFF, 5'd10, INT_MIN});
    vecs.push_back('{"rem ovf",         OP_REM,  INT_MIN,       32'hFFFF_FFFF, 5'd11, 32'd0});
    vecs.push_back('{"div -5/0",        OP_DIV,  32'hFFFF_FFFB, 32'd0,         5'd12, 32'hFFFF_FFFF});
    vecs.push_back('{"rem -5/0",        OP_REM,  32'hFFFF_FFFB, 32'd0,         5'd13, 32'hFFFF_FFFB});
    vecs.push_back('{"div 3/-7",        OP_DIV,  32'd3,         32'hFFFF_FFF9, 5'd14, 32'd0});
    vecs.push_back('{"rem 3/-7",        OP_REM,  32'd3,         32'hFFFF_FFF9, 5'd15, 32'd3});
    vecs.push_back('{"div -20/-6",      OP_DIV,  32'hFFFF_FFEC, 32'hFFFF_FFFA, 5'd16, 32'd3});
    vecs.push_back('{"rem -20/-6",      OP_REM,  32'hFFFF_FFEC, 32'hFFFF_FFFA, 5'd17, 32'hFFFF_FFFE});
    vecs.push_back('{"divu max/1",      OP_DIVU, 32'hFFFF_FFFF, 32'd1,         5'd18, 32'hFFFF_FFFF});
    vecs.push_back('{"remu max/16",     OP_REMU, 32'hFFFF_FFFF, 32'd16,        5'd19, 32'd15});

    reset_ni  = 1'b0;
    start_i   = 1'b0;
    flush_i   = 1'b0;
    select_i  = OP_ADD;
    data1_i   = '0;
    data2_i   = '0;
    dest_in_i = '0;
    tick();
    tick();
    check("reset result", result_o, 32'd0);
    check("reset dest", 32'(dest_out_o), 32'd0);
    check("reset done", 32'(done_o), 32'd0);
    check("reset busy", 32'(busy_o), 32'd0);
    check("reset stall", 32'(stall_o), 32'd0);
    reset_ni = 1'b1;

    foreach (vecs[i]) begin
      run_op(vecs[i].name, vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].dst, vecs[i].exp, 1'b1);
    end

    // FLUSH in cycle 10 abandons the op; a new op started in cycle 11 finishes in cycle 45.
    tick();
    start_i = 1'b1; select_i = OP_DIV; data1_i = 32'd1000; data2_i = 32'd3; dest_in_i = 5'd21;
    tick();
    start_i = 1'b0;
    nd = 0;
    for (int c = 1; c < 10; c++) begin
      if (done_o) nd++;
      tick();
    end
    check("flush busy@c10", 32'(busy_o), 32'd1);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check("flush busy@c11", 32'(busy_o), 32'd0);
    check("flush done@c11", 32'(done_o), 32'd0);
    check("flush result held", result_o, last_res);
    check("flush dest held", 32'(dest_out_o), 32'(last_dst));
    check("flush no early done", nd, 0);
    run_op("after flush div 100/7", OP_DIV, 32'd100, 32'd7, 5'd22, 32'd14, 1'b0);

    // Non-divide SELECT is ignored.
    tick();
    start_i = 1'b1; select_i = OP_ADD; data1_i = 32'd9; data2_i = 32'd3; dest_in_i = 5'd23;
    #1;
    check("add stall", 32'(stall_o), 32'd0);
    tick();
    start_i = 1'b0;
    check("add busy", 32'(busy_o), 32'd0);
    check("add done", 32'(done_o), 32'd0);
    check("add result held", result_o, last_res);

    // START together with FLUSH in IDLE does not accept.
    start_i = 1'b1; flush_i = 1'b1; select_i = OP_DIV; data1_i = 32'd100; data2_i = 32'd7;
    tick();
    start_i = 1'b0; flush_i = 1'b0;
    check("start+flush busy", 32'(busy_o), 32'd0);
    nd = 0;
    repeat (40) begin
      if (done_o) nd++;
      tick();
    end
    check("start+flush no done", nd, 0);

    // RESET low in cycle 20 of an op clears outputs in cycle 21 with no DONE.
    run_op("pre-reset div 77/5", OP_DIV, 32'd77, 32'd5, 5'd24, 32'd15, 1'b1);
    tick();
    start_i = 1'b1; select_i = OP_REM; data1_i = 32'd100; data2_i = 32'd7; dest_in_i = 5'd25;
    tick();
    start_i = 1'b0;
    repeat (19) tick();
    reset_ni = 1'b0;
    tick();
    check("midreset result", result_o, 32'd0);
    check("midreset dest", 32'(dest_out_o), 32'd0);
    check("midreset done", 32'(done_o), 32'd0);
    check("midreset busy", 32'(busy_o), 32'd0);
    reset_ni = 1'b1;
    last_res = '0;
    last_dst = '0;
    nd = 0;
    repeat (40) begin
      tick();
      if (done_o) nd++;
    end
    check("midreset no done", nd, 0);

    for (int i = 0; i < 150; i++) begin
      logic [4:0]  sel;
      logic [31:0] a, b;
      int          k;
      case ($urandom_range(0, 3))
        0:       sel = OP_DIV;
        1:       sel = OP_DIVU;
        2:       sel = OP_REM;
        default: sel = OP_REMU;
      endcase
      a = $urandom;
      b = $urandom;
      k = $urandom_range(0, 9);
      if (k == 0) b = 32'd0;
      else if (k == 1) b = 32'hFFFF_FFFF;
      else if (k == 2) begin a = INT_MIN; b = 32'hFFFF_FFFF; end
      else if (k == 3) b = $urandom_range(1, 15);
      else if (k == 4) a = $urandom_range(0, 1000);
      else if (k == 5) begin a = -($urandom_range(1, 100)); b = $urandom_range(1, 9); end
      run_op($sformatf("rand%0d", i), sel, a, b, 5'($urandom_range(0, 31)), ref_result(sel, a, b), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rv32im_div_sequencer.md
# rv32im_div_sequencer

Multicycle sequencer for the RV32IM M-extension divide/remainder operations (DIV, DIVU, REM, REMU). It sits beside the execute-stage ALU and accepts an operation when the pipeline presents a divide-class SELECT code. It runs a radix-2 restoring division, one quotient bit per cycle, and holds the pipeline stalled until the result is ready. Multiply and all RV32I operations remain single-cycle in the ALU and are ignored here.

## Interface
- WIDTH, 32, operand/result width; only 32 is supported by the rest of the pipeline.
- CLK  input  1  clock; all state updates on rising edge.
- RESET  input  1  synchronous, active-low reset (one clock; reset is synchronous and active-low).
- START  input  1  request; sampled only in IDLE.
- SELECT  input  5  ALU op code; 5'b10001 DIV, 5'b10101 DIVU, 5'b11001 REM, 5'b11101 REMU.
- DATA1  input  WIDTH  dividend.
- DATA2  input  WIDTH  divisor.
- DEST_IN  input  5  destination register tag.
- FLUSH  input  1  pipeline flush; abandons the current operation.
- RESULT  output  WIDTH  quotient or remainder, registered.
- DEST_OUT  output  5  tag captured at accept, registered.
- DONE  output  1  one-cycle pulse; RESULT/DEST_OUT valid.
- BUSY  output  1  registered; high in CALC and FIX.
- STALL  output  1  combinational; (START & IDLE & divide op) | BUSY.

## Operation
- Accept: IDLE & START & SELECT ∈ {10001, 10101, 11001, 11101}. Any other SELECT is ignored with no state change. START outside IDLE is ignored.
- At accept, register:
  - |DATA1| and |DATA2| (signed ops) or raw values (unsigned ops);
  - the quotient sign (DATA1[31]^DATA2[31]) and the remainder sign (DATA1[31]), signed ops only;
  - the op type and DEST_IN;
  - iteration counter = WIDTH-1.
- States:
  - IDLE: accept → CALC, or → DONE via the fast path.
  - CALC: per cycle, shift {rem,quo} left 1; trial = rem − divisor; if trial ≥ 0 then rem = trial and quo[0] = 1. Counter decrements; at counter 0 → FIX.
  - FIX: negate quo/rem per the captured signs; select quo (DIV/DIVU) or rem (REM/REMU) into RESULT → DONE.
  - DONE: DONE=1 for one cycle → IDLE.
- Special cases (all latencies follow the rules in Timing and Configuration):
  - Divide by zero: quotient = 0xFFFFFFFF, remainder = DATA1 unmodified.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
- FLUSH, any state: → IDLE next edge. No DONE. RESULT and DEST_OUT are held. Ignored in IDLE, so a simultaneous START and FLUSH in IDLE does not accept.
- RESET low: → IDLE. RESULT=0, DEST_OUT=0, DONE=0, BUSY=0, counter=0. Takes priority over FLUSH and START, including mid-operation.
- RESULT and DEST_OUT hold their value until the next DONE.

## Timing
- Accept in cycle 0, normal path:
  - CALC in cycles 1..32;
  - FIX in cycle 33;
  - DONE=1 and RESULT valid in cycle 34. Latency is WIDTH+2.
- BUSY=1 in cycles 1..33 and 0 in cycle 34.
- STALL=1 in cycles 0..33 and 0 in cycle 34, so the instruction advances in the DONE cycle.
- Fast path (macro enabled): DONE=1 in cycle 1; BUSY never asserts.
- Back-to-back: a new accept is possible in the cycle after DONE at the earliest.

## Configuration
- DIV_FAST_PATH_EN defined:
  - divide-by-zero, signed overflow, and |dividend| < |divisor| (quotient 0, remainder = DATA1) bypass CALC;
  - RESULT is registered at accept, and the FSM goes IDLE → DONE with latency 1.
- Undefined:
  - every accepted op runs the full CALC/FIX sequence with latency WIDTH+2;
  - special-case results come out of the iteration naturally (divisor 0 yields quo all-ones, rem = dividend) plus sign fix. The overflow case yields 0x80000000/0 through the unsigned-magnitude arithmetic.
- Results are bit-identical in both builds; only latency differs.

## Test plan
- DIV 100/7, accept cycle 0 → DONE cycle 34 (macro off), RESULT=14, DEST_OUT=DEST_IN. Also REM 100/7 → 2.
- REM −7 (0xFFFFFFF9) / 2 → 0xFFFFFFFF. DIV −7 / 2 → 0xFFFFFFFD (−3). DIVU 0xFFFFFFF9 / 2 → 0x7FFFFFFC.
- DIVU 5/0 → 0xFFFFFFFF; REMU 5/0 → 5. Macro on: DONE in cycle 1. Macro off: DONE in cycle 34.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same operands → 0.
- FLUSH in cycle 10 → IDLE in cycle 11, no DONE, RESULT unchanged. A new START in cycle 11 completes normally in cycle 45.
- RESET low in cycle 20 → all outputs 0 in cycle 21, no DONE. START with SELECT=5'b00000 (ADD) → STALL=0, no state change.
